fft8_bitrev_buf: RTL and testbench
==================================

FFT8_BITREV_BUF -- requirements
Module: fft8_bitrev_buf

Interface
REQ-001 Parameter: N, default 4, sample component width is 2**N bits (16 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream sample valid.
REQ-005 in_re  input  2**N  real part, two's complement.
REQ-006 in_im  input  2**N  imaginary part, two's complement.
REQ-007 in_ready  output  1  buffer can accept a sample this cycle.
REQ-008 out_valid  output  1  output sample valid.
REQ-009 out_re  output  2**N  real part, bit-reversed order.
REQ-010 out_im  output  2**N  imaginary part, bit-reversed order.
REQ-011 out_idx  output  3  output position k (0..7) within frame.
REQ-012 out_last  output  1  high with k=7.
REQ-013 out_ready  input  1  downstream butterfly/twiddle stage accepts output.

Function
REQ-014 Input transfer when in_valid && in_ready at a clock edge; output transfer when out_valid && out_ready at a clock edge.
REQ-015 Two 8-entry banks (ping-pong); write side fills one bank at natural address 0..7; the read side drains the other.
REQ-016 in_ready = 1 iff the current write bank is not full.
REQ-017 The 8th accepted write marks the bank full at that edge; the write side switches to the other bank, which accepts data only once it is empty.
REQ-018 Read order: output k carries sample bitrev3(k), i.e. samples 0,4,2,6,1,5,3,7.
REQ-019 Outputs are registered; the first output of a frame is valid on the edge after its bank became full (latency: 8th write edge + 1).
REQ-020 While out_valid && !out_ready, out_re/out_im/out_idx/out_last SHALL hold stable.
REQ-021 No bubbles within a frame: on each output transfer the next element loads at the same edge.
REQ-022 The edge that transfers k=7 frees the bank; if the other bank is already full before that edge, k=0 of the next frame loads at the same edge, else out_valid goes low.
REQ-023 A bank freed at edge E is visible to the write side (in_ready) from edge E onward; simultaneous free and write-full never drop or duplicate samples.
REQ-024 Sustained throughput is one sample per cycle with in_valid and out_ready held high.
REQ-025 Arithmetic: none; data passes through bit-exact.

Reset
REQ-026 When rst is high at an edge: out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, both banks empty, write/read bank select=0, write address=0.
REQ-027 Reset mid-frame discards partial and pending frames; after reset in_ready=1 on the first cycle. Bank memory contents are not cleared.

Configuration
REQ-028 Macro FFT8_FRAME_CNT_EN defined: extra output port frame_cnt (8 bits), reset 0, increments on each k=7 output transfer, wraps 255->0.
REQ-029 Macro undefined: no frame_cnt port or counter; all other behaviour identical.

Verification
REQ-030 Feed samples re=0..7, im=100..107 back-to-back, out_ready=1 -> out_re 0,4,2,6,1,5,3,7 on consecutive cycles, first one 1 cycle after the 8th write edge, out_last on re=7.
REQ-031 Stream 3 frames continuously, out_ready=1 -> 24 outputs with no gaps, in_ready constantly 1.
REQ-032 out_ready=0, write 16 samples -> in_ready low after 16th accept; out_valid=1 holding re=0 stable; raise out_ready -> both frames drain in order, in_ready returns 1 after first frame frees.
REQ-033 Toggle out_ready every cycle mid-frame -> each element held until accepted, no loss or duplication.
REQ-034 Assert rst after 5 writes of a frame -> out_valid=0, in_ready=1; next 8 writes form a clean frame output 0,4,2,6,1,5,3,7 of the new data.
REQ-035 With FFT8_FRAME_CNT_EN, stream 257 frames -> frame_cnt reads 1 after the last frame (wrap verified).

Source files
------------

// File: rtl/fft8_bitrev_buf.sv
// Ping-pong 8-point frame buffer: writes in natural order, reads in 3-bit bit-reversed order.
// Optional `FFT8_FRAME_CNT_EN adds an 8-bit frame_cnt output counting completed frames.
module fft8_bitrev_buf #(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [(2**N)-1:0]   in_re,
   input  logic [(2**N)-1:0]   in_im,
   output logic                in_ready,
   output logic                out_valid,
   output logic [(2**N)-1:0]   out_re,
   output logic [(2**N)-1:0]   out_im,
   output logic [2:0]          out_idx,
   input  logic                out_ready,
`ifdef FFT8_FRAME_CNT_EN
   output logic [7:0]          frame_cnt,
`endif
   output logic                out_last
);

   localparam int W = 2**N;

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   logic [W-1:0] mem_re [2][8];
   logic [W-1:0] mem_im [2][8];

   logic [1:0]   full_q, full_d;
   logic         wsel_q, wsel_d;
   logic         rsel_q, rsel_d;
   logic [2:0]   waddr_q, waddr_d;
   logic         vld_q, vld_d;
   logic [2:0]   idx_q, idx_d;
   logic [W-1:0] re_q, re_d;
   logic [W-1:0] im_q, im_d;

   logic         out_fire, rd_done, wr;
   logic         ld, ld_bank;
   logic [2:0]   ld_idx, ld_addr;
   logic         rsel_nx;

   assign rsel_nx  = ~rsel_q;
   assign out_fire = vld_q && out_ready;
   assign rd_done  = out_fire && (idx_q == 3'd7);
   // A bank drained at this edge may be refilled at the same edge, keeping full-rate streaming.
   assign in_ready = !full_q[wsel_q] || (rd_done && (rsel_q == wsel_q));
   assign wr       = in_valid && in_ready;

   // Write side: sample memory, natural order
   always_ff @(posedge clk) begin
      if (wr) begin
         mem_re[wsel_q][waddr_q] <= in_re;
         mem_im[wsel_q][waddr_q] <= in_im;
      end
   end

   always_comb begin
      full_d  = full_q;
      wsel_d  = wsel_q;
      waddr_d = waddr_q;
      rsel_d  = rsel_q;
      vld_d   = vld_q;
      idx_d   = idx_q;
      ld      = 1'b0;
      ld_bank = rsel_q;
      ld_idx  = 3'd0;
      if (rd_done) begin
         full_d[rsel_q] = 1'b0;
         rsel_d         = rsel_nx;
         if (full_q[rsel_nx]) begin
            ld      = 1'b1;
            ld_bank = rsel_nx;
         end else begin
            vld_d = 1'b0;
         end
      end else if (out_fire) begin
         ld     = 1'b1;
         ld_idx = idx_q + 3'd1;
      end else if (!vld_q && full_q[rsel_q]) begin
         ld = 1'b1;
      end
      if (ld) begin
         vld_d = 1'b1;
         idx_d = ld_idx;
      end
      if (wr) begin
         waddr_d = waddr_q + 3'd1;
         if (waddr_q == 3'd7) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = ~wsel_q;
         end
      end
   end

   // Read side: registered output, bit-reversed address
   assign ld_addr = bitrev3(ld_idx);
   assign re_d    = ld ? mem_re[ld_bank][ld_addr] : re_q;
   assign im_d    = ld ? mem_im[ld_bank][ld_addr] : im_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q  <= 2'b00;
         wsel_q  <= 1'b0;
         rsel_q  <= 1'b0;
         waddr_q <= 3'd0;
         vld_q   <= 1'b0;
         idx_q   <= 3'd0;
         re_q    <= '0;
         im_q    <= '0;
      end else begin
         full_q  <= full_d;
         wsel_q  <= wsel_d;
         rsel_q  <= rsel_d;
         waddr_q <= waddr_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
         re_q    <= re_d;
         im_q    <= im_d;
      end
   end

   assign out_valid = vld_q;
   assign out_re    = re_q;
   assign out_im    = im_q;
   assign out_idx   = idx_q;
   assign out_last  = (idx_q == 3'd7);

`ifdef FFT8_FRAME_CNT_EN
   logic [7:0] frame_q, frame_d;

   assign frame_d = rd_done ? frame_q + 8'd1 : frame_q;

   always_ff @(posedge clk) begin
      if (rst) frame_q <= 8'd0;
      else     frame_q <= frame_d;
   end

   assign frame_cnt = frame_q;
`endif

endmodule

// File: tb/tb_fft8_bitrev_buf.sv
// Self-checking bench for fft8_bitrev_buf: directed scenarios plus randomized traffic
// against a frame-level reference model (queue of complete frames, reordered by bit reversal).
module tb_fft8_bitrev_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_re = '0;
   logic [15:0] in_im = '0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_re;
   logic [15:0] out_im;
   logic [2:0]  out_idx;
   logic        out_ready = 1'b0;
   logic        out_last;
`ifdef FFT8_FRAME_CNT_EN
   logic [7:0]  frame_cnt;
`endif

   fft8_bitrev_buf #(.N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .out_ready (out_ready),
`ifdef FFT8_FRAME_CNT_EN
      .frame_cnt (frame_cnt),
`endif
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] part[$];
   logic [34:0] expq[$];
   int          pend;
   int          frames_done;

   // Per-test observation
   int          cyc;
   int          first_out;
   int          first_fire;
   int          last_fire;
   int          fire_cnt;
   int          ready_low;
   int          log_re[$];
   logic        stall_prev;
   logic [36:0] hold_val;
   int          lit[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int rev3(input int k);
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
   endfunction

   task automatic clear_obs();
      cyc = 0; first_out = -1; first_fire = -1; last_fire = -1;
      fire_cnt = 0; ready_low = 0;
      log_re.delete();
   endtask

   task automatic step(input logic v, input logic [15:0] re, input logic [15:0] im,
                       input logic ordy);
      logic [34:0] e;
      logic [2:0]  kk;
      @(negedge clk);
      in_valid = v; in_re = re; in_im = im; out_ready = ordy;
      #1;
      cyc++;
      if (stall_prev)
         check("hold", {out_valid, out_re, out_im, out_idx, out_last}, hold_val);
      check("in_ready", in_ready, (pend < 2) || (out_valid && ordy && out_idx == 3'd7));
      if (v && !in_ready) ready_low++;
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && ordy) begin
         fire_cnt++;
         if (first_fire < 0) first_fire = cyc;
         last_fire = cyc;
         log_re.push_back(int'(out_re));
         if (expq.size() == 0) begin
            check("spurious_out", 1, 0);
         end else begin
            e = expq.pop_front();
            check("out_data", {out_re, out_im, out_idx, out_last}, {e, e[2:0] == 3'd7});
            if (e[2:0] == 3'd7) begin
               pend--;
               frames_done++;
            end
         end
      end
      if (v && in_ready) begin
         part.push_back({re, im});
         if (part.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
               kk = k[2:0];
               expq.push_back({part[rev3(k)], kk});
            end
            part.delete();
            pend++;
         end
      end
      stall_prev = out_valid && !ordy;
      hold_val   = {1'b1, out_re, out_im, out_idx, out_last};
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", {out_re, out_im, out_idx, out_last}, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef FFT8_FRAME_CNT_EN
      check("rst_frame_cnt", frame_cnt, 0);
`endif
      part.delete(); expq.delete();
      pend = 0; frames_done = 0; stall_prev = 1'b0;
   endtask

   initial begin
      pend = 0; frames_done = 0; stall_prev = 1'b0; hold_val = '0;

      // Single frame, back-to-back
      do_reset();
      clear_obs();
      for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 16'(100 + i), 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
      check("latency", first_out, 10);
      check("f1_count", log_re.size(), 8);
      for (int i = 0; i < 8 && i < log_re.size(); i++) check("f1_order", log_re[i], lit[i]);

      // Three frames streamed continuously
      do_reset();
      clear_obs();
      for (int i = 0; i < 24; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
      check("stream_count", fire_cnt, 24);
      check("stream_no_gap", last_fire - first_fire + 1, 24);
      check("stream_ready", ready_low, 0);

      // Backpressure: fill both banks, then drain
      do_reset();
      clear_obs();
      for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 16'(200 + i), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_re", out_re, 0);
      for (int i = 0; i < 24; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
      check("bp_in_ready_back", in_ready, 1);
      check("bp_count", log_re.size(), 16);
      for (int i = 0; i < 16 && i < log_re.size(); i++)
         check("bp_order", log_re[i], lit[i % 8] + 8 * (i / 8));

      // out_ready toggling every cycle
      do_reset();
      clear_obs();
      for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 16'(300 + i), 1'(i % 2));
      for (int i = 0; i < 30; i++) step(1'b0, 16'h0, 16'h0, 1'(i % 2));
      check("tog_count", log_re.size(), 8);
      for (int i = 0; i < 8 && i < log_re.size(); i++) check("tog_order", log_re[i], lit[i]);

      // Reset mid-frame
      do_reset();
      clear_obs();
      for (int i = 0; i < 5; i++) step(1'b1, 16'(i + 20), 16'h0, 1'b1);
      do_reset();
      clear_obs();
      for (int i = 0; i < 8; i++) step(1'b1, 16'(50 + i), 16'(60 + i), 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
      check("mid_rst_count", log_re.size(), 8);
      for (int i = 0; i < 8 && i < log_re.size(); i++) check("mid_rst_order", log_re[i], 50 + lit[i]);

      // Randomized traffic
      do_reset();
      clear_obs();
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 9) < 6));
      for (int i = 0; i < 30; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
      check("rand_drained", expq.size(), 0);
      check("rand_progress", fire_cnt > 800, 1);

`ifdef FFT8_FRAME_CNT_EN
      // Frame counter wrap
      do_reset();
      clear_obs();
      for (int i = 0; i < 257 * 8; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
      check("frames_seen", frames_done, 257);
      check("frame_cnt_wrap", frame_cnt, frames_done % 256);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
